inv_converter_scan: RTL and testbench



---
 rtl/inv_converter_scan_pkg.sv | 56 +++++
 rtl/inv_converter_scan_if.sv | 32 +++
 rtl/inv_converter_scan_prio_enc.sv | 25 ++
 rtl/inv_converter_scan.sv | 110 +++++++++++
 tb/tb_inv_converter_scan.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/inv_converter_scan_pkg.sv
// Shared definitions for the 3-bit <-> 4-bit code converter pair.
// The forward converter and the inverse scanner both read CODE_TABLE,
// so the two directions always agree on the mapping.
package inv_conv_pkg;

    localparam int IDX_W  = 3;
    localparam int CODE_W = 4;
    localparam int N_IDX  = 1 << IDX_W;

    // Index -> code. Entry [i] is the code for index i.
    // Codes 0, 3, 7 and 10-15 never appear.
    // Code 1 appears twice (indices 0 and 4).
    localparam logic [N_IDX-1:0][CODE_W-1:0] CODE_TABLE = {
        4'd9,   // 7
        4'd6,   // 6
        4'd4,   // 5
        4'd1,   // 4
        4'd2,   // 3
        4'd5,   // 2
        4'd8,   // 1
        4'd1    // 0
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        MISS = 2'd2
    } state_t;

    // Forward direction: index to code.
    function automatic logic [CODE_W-1:0] fwd_code(input logic [IDX_W-1:0] idx);
        return CODE_TABLE[idx];
    endfunction

    // Compares one code against every table entry at once.
    // The result has one bit per matching index.
    function automatic logic [N_IDX-1:0] hit_mask(input logic [CODE_W-1:0] code);
        logic [N_IDX-1:0] m;
        m = '0;
        for (int i = 0; i < N_IDX; i++) begin
            m[i] = (CODE_TABLE[i] == code);
        end
        return m;
    endfunction

    // Counts the set bits of a hit mask. The result ranges from 0 to 8.
    function automatic logic [3:0] count_ones(input logic [N_IDX-1:0] m);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < N_IDX; i++) begin
            c = c + {3'd0, m[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/inv_converter_scan_if.sv
// Request/response bundle between a code consumer and inv_converter_scan.
// The master side issues codes and sinks index beats.
// The slave side is the scanner. rsp_count_o exists only with INV_CONV_COUNT_EN.
interface inv_converter_scan_if;
    import inv_conv_pkg::*;

    logic              req_valid_i;
    logic              req_ready_o;
    logic [CODE_W-1:0] req_data_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [IDX_W-1:0]  rsp_index_o;
    logic              rsp_hit_o;
    logic              rsp_last_o;
`ifdef INV_CONV_COUNT_EN
    logic [3:0]        rsp_count_o;

    modport master (output req_valid_i, req_data_i, rsp_ready_i,
                    input  req_ready_o, rsp_valid_o, rsp_index_o, rsp_hit_o,
                           rsp_last_o, rsp_count_o);
    modport slave  (input  req_valid_i, req_data_i, rsp_ready_i,
                    output req_ready_o, rsp_valid_o, rsp_index_o, rsp_hit_o,
                           rsp_last_o, rsp_count_o);
`else
    modport master (output req_valid_i, req_data_i, rsp_ready_i,
                    input  req_ready_o, rsp_valid_o, rsp_index_o, rsp_hit_o,
                           rsp_last_o);
    modport slave  (input  req_valid_i, req_data_i, rsp_ready_i,
                    output req_ready_o, rsp_valid_o, rsp_index_o, rsp_hit_o,
                           rsp_last_o);
`endif
endinterface

// File: rtl/inv_converter_scan_prio_enc.sv
// Lowest-set-bit priority encoder over an 8-bit hit mask.
// Purely combinational, with zero latency and no backpressure.
// one_hot is also true for an all-zero mask; nonzero separates those two cases.
module inv_conv_prio_enc
    import inv_conv_pkg::*;
(
    input  logic [N_IDX-1:0] mask,
    output logic [IDX_W-1:0] lo_idx,
    output logic             one_hot,
    output logic             nonzero
);

    // Scan from the top down, so the lowest set bit is the last one written.
    always_comb begin
        lo_idx = '0;
        for (int i = N_IDX - 1; i >= 0; i--) begin
            if (mask[i]) begin
                lo_idx = IDX_W'(i);
            end
        end
        one_hot = ((mask & (mask - N_IDX'(1))) == '0);
        nonzero = |mask;
    end

endmodule

// File: rtl/inv_converter_scan.sv
// Reverse code lookup. It streams every index whose table code matches the request.
// The first response beat appears one cycle after acceptance, then one beat per cycle.
// Response outputs hold while ready is low. No new request is taken until the last beat.
// Optional rsp_count_o output is enabled with INV_CONV_COUNT_EN.
module inv_converter_scan
    import inv_conv_pkg::*;
#(
    parameter bit FIRST_ONLY = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    inv_converter_scan_if.slave  bus
);

    state_t           state, state_nxt;
    logic [N_IDX-1:0] mask, mask_nxt;
    logic [N_IDX-1:0] req_mask, req_mask_sel;
    logic [IDX_W-1:0] lo_idx;
    logic             one_hot, nonzero;
    logic             accept;

    inv_conv_prio_enc u_prio_enc (
        .mask    (mask),
        .lo_idx  (lo_idx),
        .one_hot (one_hot),
        .nonzero (nonzero)
    );

    // Match the incoming code against the whole table.
    // Optionally keep only the lowest match.
    always_comb begin
        req_mask     = hit_mask(bus.req_data_i);
        req_mask_sel = FIRST_ONLY ? (req_mask & (~req_mask + N_IDX'(1))) : req_mask;
    end

    assign accept = (state == IDLE) && bus.req_valid_i;

    // Next-state logic: load the mask on acceptance and peel one bit per handshake.
    always_comb begin
        state_nxt = state;
        mask_nxt  = mask;
        case (state)
            IDLE: begin
                if (bus.req_valid_i) begin
                    mask_nxt  = req_mask_sel;
                    state_nxt = (|req_mask_sel) ? EMIT : MISS;
                end
            end
            EMIT: begin
                if (bus.rsp_ready_i) begin
                    mask_nxt = mask & ~(N_IDX'(1) << lo_idx);
                    if (one_hot || !nonzero) begin
                        state_nxt = IDLE;
                    end
                end
            end
            MISS: begin
                if (bus.rsp_ready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                mask_nxt  = '0;
            end
        endcase
    end

    // State and mask registers. Reset drops any in-flight request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            mask  <= '0;
        end else begin
            state <= state_nxt;
            mask  <= mask_nxt;
        end
    end

    // Response outputs depend only on state and mask. No req_* signal reaches them combinationally.
    always_comb begin
        bus.req_ready_o = (state == IDLE) && !rst_i;
        bus.rsp_valid_o = (state == EMIT) || (state == MISS);
        bus.rsp_hit_o   = (state == EMIT);
        bus.rsp_index_o = (state == EMIT) ? lo_idx : '0;
        bus.rsp_last_o  = (state == MISS) || ((state == EMIT) && one_hot);
    end

`ifdef INV_CONV_COUNT_EN
    logic [3:0] count;

    // Full table match count, captured at acceptance even in FIRST_ONLY mode.
    // It clears once the request completes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count <= '0;
        end else if (accept) begin
            count <= count_ones(req_mask);
        end else if (bus.rsp_valid_o && bus.rsp_ready_i && bus.rsp_last_o) begin
            count <= '0;
        end
    end

    assign bus.rsp_count_o = count;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_inv_converter_scan.sv
// Directed bench for inv_converter_scan.
// It drives one full-stream instance and one FIRST_ONLY instance.
// Expected streams come from a hand-written per-code table.
module tb_inv_converter_scan;
    import inv_conv_pkg::*;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    inv_converter_scan_if bus0 ();
    inv_converter_scan_if bus1 ();

    inv_converter_scan #(.FIRST_ONLY(1'b0)) dut_all (.clk_i(clk_i), .rst_i(rst_i), .bus(bus0));
    inv_converter_scan #(.FIRST_ONLY(1'b1)) dut_first (.clk_i(clk_i), .rst_i(rst_i), .bus(bus1));

    // Stimulus goes to the selected instance. The other instance sees idle inputs.
    int         sel = 0;
    logic       req_valid = 1'b0;
    logic [3:0] req_data  = 4'd0;
    logic       rsp_ready = 1'b0;

    assign bus0.req_valid_i = (sel == 0) && req_valid;
    assign bus0.req_data_i  = req_data;
    assign bus0.rsp_ready_i = (sel == 0) && rsp_ready;
    assign bus1.req_valid_i = (sel == 1) && req_valid;
    assign bus1.req_data_i  = req_data;
    assign bus1.rsp_ready_i = (sel == 1) && rsp_ready;

    logic       o_req_ready, o_valid, o_hit, o_last;
    logic [2:0] o_index;
    logic [3:0] o_count;
    always_comb begin
        o_req_ready = (sel == 0) ? bus0.req_ready_o : bus1.req_ready_o;
        o_valid     = (sel == 0) ? bus0.rsp_valid_o : bus1.rsp_valid_o;
        o_hit       = (sel == 0) ? bus0.rsp_hit_o   : bus1.rsp_hit_o;
        o_last      = (sel == 0) ? bus0.rsp_last_o  : bus1.rsp_last_o;
        o_index     = (sel == 0) ? bus0.rsp_index_o : bus1.rsp_index_o;
`ifdef INV_CONV_COUNT_EN
        o_count     = (sel == 0) ? bus0.rsp_count_o : bus1.rsp_count_o;
`else
        o_count     = 4'd0;
`endif
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic check_count(input string name, input int exp);
`ifdef INV_CONV_COUNT_EN
        check(name, int'(o_count), exp);
`else
        if (exp < 0) $display("unused %s", name);
`endif
    endtask

    // Expected result per code.
    // nb is the number of matches (0 = miss), with idx0 < idx1.
    typedef struct {
        logic [3:0] code;
        int         nb;
        int         idx0;
        int         idx1;
    } vec_t;

    vec_t vecs [16];

    // Issues one request with ready held high.
    // Checks every beat against the expected stream, then checks the return to idle.
    task automatic run_stream(input vec_t v, input bit first_only);
        int    beats;
        string tag;
        tag   = $sformatf("s%0d_code%0d", sel, v.code);
        beats = (first_only && v.nb > 1) ? 1 : v.nb;
        @(negedge clk_i);
        check({tag, "_req_ready"}, int'(o_req_ready), 1);
        req_valid = 1'b1;
        req_data  = v.code;
        rsp_ready = 1'b1;
        @(negedge clk_i);
        req_valid = 1'b0;
        if (beats == 0) begin
            check({tag, "_miss_valid"}, int'(o_valid), 1);
            check({tag, "_miss_hit"},   int'(o_hit),   0);
            check({tag, "_miss_index"}, int'(o_index), 0);
            check({tag, "_miss_last"},  int'(o_last),  1);
            check_count({tag, "_miss_count"}, 0);
            @(negedge clk_i);
        end else begin
            for (int b = 0; b < beats; b++) begin
                check($sformatf("%s_b%0d_valid", tag, b), int'(o_valid), 1);
                check($sformatf("%s_b%0d_hit", tag, b),   int'(o_hit),   1);
                check($sformatf("%s_b%0d_index", tag, b), int'(o_index), (b == 0) ? v.idx0 : v.idx1);
                check($sformatf("%s_b%0d_last", tag, b),  int'(o_last),  (b == beats - 1) ? 1 : 0);
                check_count($sformatf("%s_b%0d_count", tag, b), v.nb);
                check($sformatf("%s_b%0d_req_ready", tag, b), int'(o_req_ready), 0);
                @(negedge clk_i);
            end
        end
        check({tag, "_end_valid"}, int'(o_valid), 0);
        check({tag, "_end_ready"}, int'(o_req_ready), 1);
        rsp_ready = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{4'd0,  0, 0, 0};
        vecs[1]  = '{4'd1,  2, 0, 4};
        vecs[2]  = '{4'd2,  1, 3, 0};
        vecs[3]  = '{4'd3,  0, 0, 0};
        vecs[4]  = '{4'd4,  1, 5, 0};
        vecs[5]  = '{4'd5,  1, 2, 0};
        vecs[6]  = '{4'd6,  1, 6, 0};
        vecs[7]  = '{4'd7,  0, 0, 0};
        vecs[8]  = '{4'd8,  1, 1, 0};
        vecs[9]  = '{4'd9,  1, 7, 0};
        vecs[10] = '{4'd10, 0, 0, 0};
        vecs[11] = '{4'd11, 0, 0, 0};
        vecs[12] = '{4'd12, 0, 0, 0};
        vecs[13] = '{4'd13, 0, 0, 0};
        vecs[14] = '{4'd14, 0, 0, 0};
        vecs[15] = '{4'd15, 0, 0, 0};

        // Power-on reset: ready stays low while reset is held.
        repeat (2) @(negedge clk_i);
        check("rst_req_ready_low", int'(o_req_ready), 0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_req_ready", int'(o_req_ready), 1);
        check("rst_valid", int'(o_valid), 0);
        check("rst_index", int'(o_index), 0);
        check("rst_hit",   int'(o_hit),   0);
        check("rst_last",  int'(o_last),  0);
        check_count("rst_count", 0);

        // Called-out codes first, then the full sweep on the all-matches instance.
        sel = 0;
        run_stream(vecs[1], 1'b0);
        run_stream(vecs[9], 1'b0);
        run_stream(vecs[8], 1'b0);
        run_stream(vecs[6], 1'b0);
        for (int i = 0; i < 16; i++) run_stream(vecs[i], 1'b0);

        // Backpressure: hold beat 0 for three cycles.
        // A stray request pulse during the stream must be ignored.
        @(negedge clk_i);
        req_valid = 1'b1;
        req_data  = 4'd1;
        rsp_ready = 1'b0;
        @(negedge clk_i);
        req_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("bp_c%0d_valid", c), int'(o_valid), 1);
            check($sformatf("bp_c%0d_index", c), int'(o_index), 0);
            check($sformatf("bp_c%0d_last", c),  int'(o_last),  0);
            check($sformatf("bp_c%0d_req_ready", c), int'(o_req_ready), 0);
            check_count($sformatf("bp_c%0d_count", c), 2);
            req_valid = (c == 1);
            req_data  = 4'd9;
            @(negedge clk_i);
        end
        req_valid = 1'b0;
        check("bp_hold_index", int'(o_index), 0);
        rsp_ready = 1'b1;
        @(negedge clk_i);
        check("bp_b1_index", int'(o_index), 4);
        check("bp_b1_last",  int'(o_last),  1);
        @(negedge clk_i);
        check("bp_idle_valid", int'(o_valid), 0);
        check("bp_idle_ready", int'(o_req_ready), 1);
        rsp_ready = 1'b0;

        // Reset arrives mid-stream. The stream is dropped and the outputs return to their reset values.
        req_valid = 1'b1;
        req_data  = 4'd1;
        @(negedge clk_i);
        req_valid = 1'b0;
        check("mid_valid_before", int'(o_valid), 1);
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check("mid_rst_ready_low", int'(o_req_ready), 0);
        check("mid_rst_valid", int'(o_valid), 0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("mid_after_ready", int'(o_req_ready), 1);
        check("mid_after_valid", int'(o_valid), 0);
        check("mid_after_index", int'(o_index), 0);
        check("mid_after_hit",   int'(o_hit),   0);
        check("mid_after_last",  int'(o_last),  0);
        check_count("mid_after_count", 0);

        // FIRST_ONLY instance: code 1 yields only index 0, then the full sweep runs.
        sel = 1;
        run_stream(vecs[1], 1'b1);
        for (int i = 0; i < 16; i++) run_stream(vecs[i], 1'b1);

        @(negedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global guard so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish, required finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
